// File: rtl/gate_tb_pkg.sv
// Shared definitions for the gate truth-table benches: checker state encoding,
// a constant-safe ceil(log2) helper and truth tables for the gate library.
package gate_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit i is the gate output when the input vector equals i.
  localparam logic [7:0] TT_AND3  = 8'h80;
  localparam logic [7:0] TT_OR3   = 8'hFE;
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_XOR3  = 8'h96;

  // Never returns 0, so counters sized with it always have at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time counter: cleared by load, advanced by en, flags the last settle
// cycle of the vector currently applied.
module tt_settle_timer
  import gate_tb_pkg::*;
#(
  parameter int unsigned SETTLE = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  // Sized for SETTLE: the count steps one past SETTLE-1 on the exit edge.
  localparam int unsigned CW = clog2(SETTLE + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table exerciser: sweeps every input vector of an N_IN-input gate,
// lets each settle, samples the response and scores it against EXPECT.
module gate_tt_checker
  import gate_tb_pkg::*;
#(
  parameter int unsigned               N_IN   = 3,
  parameter logic [(2**N_IN)-1:0]      EXPECT = 8'h80,
  parameter int unsigned               SETTLE = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        x_out,
  input  logic                   y_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_cnt,
  output logic [(2**N_IN)-1:0]   fail_vec,
  output logic [N_IN-1:0]        vec_idx
);

  localparam int unsigned NVEC = 2 ** N_IN;

  state_e               state_q, state_d;
  logic [N_IN-1:0]      vec_q, vec_d;
  logic [N_IN:0]        err_q, err_d;
  logic [NVEC-1:0]      fail_q, fail_d;
  logic                 pass_q, pass_d;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_expire;
  logic                 mismatch;
  logic                 last_vec;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Case inequality so a floating (X/Z) gate output is scored as a failure.
  assign mismatch = (y_in !== EXPECT[vec_q]);
  assign last_vec = (vec_q == N_IN'(NVEC - 1));

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d      = '0;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        timer_en = 1'b1;
        if (timer_expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d         = err_q + 1'b1;
          fail_d[vec_q] = 1'b1;
        end
        // The verdict is registered on the way into DONE so it is valid with done.
        if (last_vec) begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d      = vec_q + 1'b1;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign x_out    = vec_q;
  assign vec_idx  = vec_q;
  assign busy     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Randomised bench for gate_tt_checker: a timeline model derived from the sweep
// rules predicts every output each cycle; literal cases pin the model.
module tb_gate_tt_checker;
  import gate_tb_pkg::*;

  localparam int N   = 3;
  localparam int S   = 5;
  localparam int NV  = 1 << N;
  localparam int PER = NV * (S + 1);
  localparam logic [NV-1:0] EXP = TT_AND3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          yIn;
  logic [N-1:0]  xOut;
  logic [N-1:0]  vecIdx;
  logic          busy;
  logic          done;
  logic          pass;
  logic [N:0]    errCnt;
  logic [NV-1:0] failVec;

  logic [NV-1:0] gateTt;
  int            zVec;
  int            assertCount = 0;
  int            failCount = 0;
  int            tSince = -1;
  logic [NV-1:0] mmModel = '0;

  always #5 clk = ~clk;

  gate_tt_checker #(
    .N_IN   (N),
    .EXPECT (EXP),
    .SETTLE (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_out    (xOut),
    .y_in     (yIn),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (errCnt),
    .fail_vec (failVec),
    .vec_idx  (vecIdx)
  );

  // Gate under test: a truth table, optionally floating for one vector.
  always_comb begin
    if (zVec >= 0 && int'(xOut) == zVec) yIn = 1'bz;
    else yIn = gateTt[xOut];
  end

  function automatic logic [NV-1:0] sweepMismatch(input logic [NV-1:0] tt, input int zv);
    logic [NV-1:0] m;
    logic yv;
    for (int i = 0; i < NV; i++) begin
      yv   = (i == zv) ? 1'bz : tt[i];
      m[i] = (yv !== EXP[i]);
    end
    return m;
  endfunction

  function automatic int popCount(input logic [NV-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < NV; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tSince counts edges since the accepted start; > PER means idle again.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tSince = -1;
    end else if ((tSince < 0 || tSince > PER) && start === 1'b1) begin
      tSince  = 0;
      mmModel = sweepMismatch(gateTt, zVec);
    end else if (tSince >= 0 && tSince <= PER) begin
      tSince++;
    end
  end

  always @(negedge clk) begin
    logic          busyE, doneE, passE;
    int            vecE, errE, samp;
    logic [NV-1:0] failE;
    busyE = 0; doneE = 0; passE = 0; vecE = 0; errE = 0; failE = '0;
    if (tSince >= 0) begin
      samp = tSince / (S + 1);
      if (samp > NV) samp = NV;
      for (int i = 0; i < NV; i++) failE[i] = (i < samp) ? mmModel[i] : 1'b0;
      errE = popCount(failE);
      if (tSince < PER) begin
        busyE = 1; vecE = tSince / (S + 1);
      end else begin
        doneE = (tSince == PER); vecE = NV - 1; passE = (errE == 0);
      end
    end
    checkOutput("cyc_busy", busy, busyE);
    checkOutput("cyc_done", done, doneE);
    checkOutput("cyc_pass", pass, passE);
    checkOutput("cyc_x_out", xOut, vecE);
    checkOutput("cyc_vec_idx", vecIdx, vecE);
    checkOutput("cyc_err_cnt", errCnt, errE);
    checkOutput("cyc_fail_vec", failVec, failE);
  end

  task automatic waitDone(input string name, input int extraAt);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 4 * PER) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1;
      else begin
        #2;
        if (n == extraAt) start = 1'b1;
        else if (n == extraAt + 1) start = 1'b0;
      end
    end
    checkOutput({name, "_done_cycle"}, n, PER + 1);
  endtask

  task automatic applyStimulus(input string name, input logic [NV-1:0] tt, input int zv, input int extraAt);
    gateTt = tt; zVec = zv;
    @(negedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    waitDone(name, extraAt);
  endtask

  task automatic checkResult(input string name, input int errE, input logic [NV-1:0] failE, input logic passE);
    checkOutput({name, "_err_cnt"}, errCnt, errE);
    checkOutput({name, "_fail_vec"}, failVec, failE);
    checkOutput({name, "_pass"}, pass, passE);
  endtask

  task automatic checkZeroed(input string name);
    checkOutput({name, "_x_out"}, xOut, 0);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_done"}, done, 0);
    checkResult(name, 0, '0, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; gateTt = TT_AND3; zVec = -1;
    #12;
    checkZeroed("reset");
    @(negedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus("and3", TT_AND3, -1, 0);
    checkResult("and3", 0, 8'h00, 1'b1);
    applyStimulus("tied0", 8'h00, -1, 0);
    checkResult("tied0", 1, 8'h80, 1'b0);
    applyStimulus("tied1", 8'hFF, -1, 0);
    checkResult("tied1", 7, 8'h7F, 1'b0);
    applyStimulus("nand3", TT_NAND3, -1, 0);
    checkResult("nand3", 8, 8'hFF, 1'b0);
    applyStimulus("z5", TT_AND3, 5, 0);
    applyStimulus("extra_start", TT_OR3, -1, 10);
    checkResult("extra_start", 6, 8'h7E, 1'b0);

    // start held from the DONE cycle: ignored there, accepted in the next IDLE cycle.
    gateTt = TT_AND3; zVec = -1;
    #2 start = 1'b1;
    @(posedge clk);
    @(posedge clk); #2 start = 1'b0;
    waitDone("back_to_back", 0);
    checkResult("back_to_back", 0, 8'h00, 1'b1);

    gateTt = TT_XOR3;
    @(negedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    n = 0;
    while (vecIdx !== 3'd3 && n < 4 * PER) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_reach_vec3", vecIdx, 3);
    #2 rst = 1'b1;
    #1 checkZeroed("mid_reset");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus("after_reset", TT_AND3, -1, 0);
    checkResult("after_reset", 0, 8'h00, 1'b1);

    for (int k = 0; k < 10; k++) begin
      logic [NV-1:0] tt;
      int zv, ex;
      tt = NV'($urandom);
      zv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NV - 1)) : -1;
      ex = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, PER - 2)) : 0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      applyStimulus("random", tt, zv, ex);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
